// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: request/result bundle between a requester and the
// bit-serial add/subtract controller.
//   master (requester): drives start, sub, a, b, cin; observes busy, done,
//                       sum, cout, ovf.
//   slave (controller): the reverse.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract controller. One 1-bit full adder
// is stepped over WIDTH cycles, LSB first. The operands sit in shift
// registers, the carry is held in a flop between bits, and the result is
// shifted into the sum register from the top.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - serial_add_ctrl_if.slave: start/sub/a/b/cin in,
//          busy/done/sum/cout/ovf out
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 1-bit full adder cell: returns {carry_out, sum}
  function automatic logic [1:0] full_adder(input logic x, input logic y, input logic ci);
    full_adder = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic             load_s;
  logic             step_s;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             c_msb_in_r;
  logic             cout_r;
  logic             ovf_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       fa_s;
  logic             fa_sum_s;
  logic             fa_cout_s;

  assign fa_s      = full_adder(op_a_r[0], op_b_r[0], carry_r);
  assign fa_sum_s  = fa_s[0];
  assign fa_cout_s = fa_s[1];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and datapath strobes
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt_s = ST_RUN;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Operand capture, serial stepping and result/flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_r     <= {WIDTH{1'b0}};
      op_b_r     <= {WIDTH{1'b0}};
      sum_r      <= {WIDTH{1'b0}};
      carry_r    <= 1'b0;
      c_msb_in_r <= 1'b0;
      cout_r     <= 1'b0;
      ovf_r      <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
    end else if (load_s) begin
      // Subtraction is a + ~b + 1: invert b here and force the carry-in.
      op_a_r  <= bus.a;
      op_b_r  <= bus.sub ? ~bus.b : bus.b;
      carry_r <= bus.sub ? 1'b1 : bus.cin;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (step_s) begin
      sum_r   <= {fa_sum_s, sum_r[WIDTH-1:1]};
      op_a_r  <= {1'b0, op_a_r[WIDTH-1:1]};
      op_b_r  <= {1'b0, op_b_r[WIDTH-1:1]};
      carry_r <= fa_cout_s;
      // The carry produced by bit WIDTH-2 is the carry into the MSB.
      if (cnt_r == CNT_PEN) begin
        c_msb_in_r <= fa_cout_s;
      end else begin
        c_msb_in_r <= c_msb_in_r;
      end
      // Counter parks on the last bit so it never wraps within an operation.
      if (cnt_r == CNT_LAST) begin
        cout_r <= fa_cout_s;
        ovf_r  <= c_msb_in_r ^ fa_cout_s;
        cnt_r  <= cnt_r;
      end else begin
        cout_r <= cout_r;
        ovf_r  <= ovf_r;
        cnt_r  <= cnt_r + CNT_W'(1);
      end
    end else begin
      op_a_r <= op_a_r;
    end
  end

  // busy/done decode straight from the state register; no path from start.
  assign bus.busy = (state_r != ST_IDLE);
  assign bus.done = (state_r == ST_DONE);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed-vector bench for serial_add_ctrl (WIDTH=8).
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation, wait (bounded) for done, check latency, busy length
  // and the result; then check the return to idle.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub,
                        input logic [7:0] e_sum, input logic e_cout, input logic e_ovf);
    int lat;
    int busy_n;
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    // scramble captured inputs; they must not matter any more
    bus.a = ~a; bus.b = ~b; bus.cin = ~cin; bus.sub = ~sub;
    lat = 0;
    busy_n = bus.busy ? 1 : 0;
    while (!bus.done && lat < 20) begin
      tick();
      lat++;
      if (bus.busy) busy_n++;
    end
    check_eq({tag, "_lat"}, lat, WIDTH);
    check_eq({tag, "_busy_len"}, busy_n, WIDTH + 1);
    check_eq({tag, "_sum"}, bus.sum, e_sum);
    check_eq({tag, "_cout"}, bus.cout, e_cout);
    check_eq({tag, "_ovf"}, bus.ovf, e_ovf);
    tick();
    check_eq({tag, "_idle"}, {bus.busy, bus.done}, 2'b00);
    check_eq({tag, "_hold"}, bus.sum, e_sum);
  endtask

  initial begin
    int lat;
    int dones;
    n_checks = 0;
    n_fails  = 0;
    bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0;
    bus.a = 8'h00; bus.b = 8'h00;
    rst = 1'b1;
    #2;
    check_eq("rst_out", {bus.busy, bus.done, bus.sum, bus.cout, bus.ovf}, 12'h000);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_eq("rst_idle", {bus.busy, bus.done}, 2'b00);

    run_op("add",  8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1);
    run_op("addc", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("sub1", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0);
    run_op("sub2", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    run_op("sub3", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Start pulses during RUN and DONE must be ignored.
    bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.a = 8'hF0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    dones = 0;
    while (!bus.done && lat < 20) begin
      tick();
      lat++;
    end
    check_eq("busy_start_done_seen", bus.done, 1'b1);
    dones = 1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("busy_start_idle", bus.busy, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) dones++;
    end
    check_eq("busy_start_ndone", dones, 1);
    check_eq("busy_start_sum", bus.sum, 8'h02);

    // Back-to-back with start held: second op accepted in the IDLE cycle.
    bus.a = 8'h05; bus.b = 8'h06; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    tick();
    for (int i = 0; i < WIDTH; i++) tick();
    check_eq("b2b_done1", bus.done, 1'b1);
    check_eq("b2b_sum1", bus.sum, 8'h0B);
    bus.a = 8'h20; bus.b = 8'h01;
    tick();
    check_eq("b2b_idle", bus.busy, 1'b0);
    tick();
    bus.start = 1'b0;
    check_eq("b2b_accept", bus.busy, 1'b1);
    for (int i = 0; i < WIDTH; i++) tick();
    check_eq("b2b_done2", bus.done, 1'b1);
    check_eq("b2b_sum2", bus.sum, 8'h21);
    tick();

    // Reset mid-operation after a result with cout=1/ovf=1.
    run_op("pre_rst", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    bus.a = 8'h77; bus.b = 8'h11; bus.sub = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_out", {bus.busy, bus.done, bus.sum, bus.cout, bus.ovf}, 12'h000);
    tick();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) dones++;
    end
    check_eq("midrst_nodone", dones, 0);
    check_eq("midrst_sum", bus.sum, 8'h00);
    run_op("post_rst", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
